// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding unit: FSM encoding and the control word.
package pipe_hazard_unit_pkg;

    typedef enum logic [0:0] {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_id;
        logic flush_id;
        logic bubble_exe;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_NOP_CTRL = '{default: 1'b0};

    // A killed ID slot can never stall, so flush always masks the stall request.
    function automatic hz_ctrl_t hz_make_ctrl(input logic flush, input logic stall);
        hz_ctrl_t c;
        c            = HZ_NOP_CTRL;
        c.flush_id   = flush;
        c.stall_pc   = stall & ~flush;
        c.stall_id   = stall & ~flush;
        c.bubble_exe = flush | stall;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_scoreboard.sv
// In-flight register-write tracker: DEPTH-slot shift register (0=EXE ... DEPTH-1=WB) with bubble insert.
module pipe_hazard_unit_scoreboard #(
    parameter int ASIZE = 4,
    parameter int DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [ASIZE-1:0]            in_waddr,
    input  logic                        in_is_load,
    input  logic                        bubble,
    output logic [DEPTH-1:0]            slot_valid,
    output logic [DEPTH-1:0][ASIZE-1:0] slot_waddr,
    output logic [DEPTH-1:0]            slot_is_load
);

    logic [DEPTH-1:0]            valid_d, valid_q;
    logic [DEPTH-1:0][ASIZE-1:0] waddr_d, waddr_q;
    logic [DEPTH-1:0]            load_d, load_q;

    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], in_valid & ~bubble};
        waddr_d = {waddr_q[DEPTH-2:0], in_waddr};
        load_d  = {load_q[DEPTH-2:0], in_is_load & ~bubble};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            waddr_q <= '0;
            load_q  <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            load_q  <= load_d;
        end
    end

    assign slot_valid   = valid_q;
    assign slot_waddr   = waddr_q;
    assign slot_is_load = load_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside decode: slot match, load-use stall, redirect flush FSM.
// HAZ_FWD_EN enables forwarding; without it the unit is interlock-only (any in-flight match stalls).
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DSIZE    = 16,
    parameter int ASIZE    = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FLUSH_N  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [ASIZE-1:0]       id_raddr1,
    input  logic [ASIZE-1:0]       id_raddr2,
    input  logic                   id_ren1,
    input  logic                   id_ren2,
    input  logic [ASIZE-1:0]       id_waddr,
    input  logic                   id_wen,
    input  logic                   id_is_load,
    input  logic [DSIZE-1:0]       id_rdata1,
    input  logic [DSIZE-1:0]       id_rdata2,
    input  logic [DEPTH*DSIZE-1:0] slot_wdata,
    input  logic                   exe_redirect,
    output logic [DSIZE-1:0]       fwd_rdata1,
    output logic [DSIZE-1:0]       fwd_rdata2,
    output logic                   stall_pc,
    output logic                   stall_id,
    output logic                   flush_id,
    output logic                   bubble_exe
);

    localparam int CW = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
    localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_N - 1);

    hz_state_e               state_d, state_q;
    logic [CW-1:0]           cnt_d, cnt_q;
    logic [DEPTH-1:0]        slot_valid, slot_is_load;
    logic [DEPTH-1:0][ASIZE-1:0] slot_waddr;
    logic                    hit1, hit2, lu1, lu2;
    logic [DSIZE-1:0]        sel1, sel2, fwd_sel1, fwd_sel2;
    logic                    need_stall, flush_act;
    hz_ctrl_t                ctrl;

    pipe_hazard_unit_scoreboard #(
        .ASIZE (ASIZE),
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (id_valid & id_wen),
        .in_waddr     (id_waddr),
        .in_is_load   (id_is_load),
        .bubble       (ctrl.bubble_exe),
        .slot_valid   (slot_valid),
        .slot_waddr   (slot_waddr),
        .slot_is_load (slot_is_load)
    );

    // Scan oldest to youngest so the youngest matching slot overrides.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        lu1  = 1'b0;
        lu2  = 1'b0;
        sel1 = id_rdata1;
        sel2 = id_rdata2;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_valid[i] && id_ren1 && (slot_waddr[i] == id_raddr1)) begin
                hit1 = 1'b1;
                lu1  = slot_is_load[i] && (i < LOAD_LAT);
                sel1 = slot_wdata[i*DSIZE +: DSIZE];
            end
            if (slot_valid[i] && id_ren2 && (slot_waddr[i] == id_raddr2)) begin
                hit2 = 1'b1;
                lu2  = slot_is_load[i] && (i < LOAD_LAT);
                sel2 = slot_wdata[i*DSIZE +: DSIZE];
            end
        end
    end

`ifdef HAZ_FWD_EN
    assign need_stall = lu1 | lu2;
    assign fwd_sel1   = (hit1 && !lu1) ? sel1 : id_rdata1;
    assign fwd_sel2   = (hit2 && !lu2) ? sel2 : id_rdata2;
`else
    logic fwd_unused;
    assign need_stall = hit1 | hit2;
    assign fwd_sel1   = id_rdata1;
    assign fwd_sel2   = id_rdata2;
    assign fwd_unused = ^{sel1, sel2, lu1, lu2};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_act = exe_redirect | (state_q == HZ_FLUSH);
        if (exe_redirect) begin
            cnt_d   = FLUSH_RELOAD;
            state_d = (FLUSH_RELOAD != '0) ? HZ_FLUSH : HZ_RUN;
        end else if (state_q == HZ_FLUSH) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) begin
                state_d = HZ_RUN;
            end
        end
        ctrl = rst ? hz_make_ctrl(flush_act, need_stall) : HZ_NOP_CTRL;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_pc   = ctrl.stall_pc;
    assign stall_id   = ctrl.stall_id;
    assign flush_id   = ctrl.flush_id;
    assign bubble_exe = ctrl.bubble_exe;
    assign fwd_rdata1 = rst ? fwd_sel1 : id_rdata1;
    assign fwd_rdata2 = rst ? fwd_sel2 : id_rdata2;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_unit;

    localparam int DSIZE    = 16;
    localparam int ASIZE    = 4;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int FLUSH_N  = 2;
    localparam int EW       = 2 * DSIZE + 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic                   id_valid = 1'b0, id_ren1 = 1'b0, id_ren2 = 1'b0;
    logic                   id_wen = 1'b0, id_is_load = 1'b0, exe_redirect = 1'b0;
    logic [ASIZE-1:0]       id_raddr1 = '0, id_raddr2 = '0, id_waddr = '0;
    logic [DSIZE-1:0]       id_rdata1 = 16'h1234, id_rdata2 = 16'h5678;
    logic [DEPTH*DSIZE-1:0] slot_wdata = '0;
    logic [DSIZE-1:0]       fwd_rdata1, fwd_rdata2;
    logic                   stall_pc, stall_id, flush_id, bubble_exe;

    pipe_hazard_unit #(
        .DSIZE (DSIZE), .ASIZE (ASIZE), .DEPTH (DEPTH), .LOAD_LAT (LOAD_LAT), .FLUSH_N (FLUSH_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_raddr1    (id_raddr1),
        .id_raddr2    (id_raddr2),
        .id_ren1      (id_ren1),
        .id_ren2      (id_ren2),
        .id_waddr     (id_waddr),
        .id_wen       (id_wen),
        .id_is_load   (id_is_load),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .slot_wdata   (slot_wdata),
        .exe_redirect (exe_redirect),
        .fwd_rdata1   (fwd_rdata1),
        .fwd_rdata2   (fwd_rdata2),
        .stall_pc     (stall_pc),
        .stall_id     (stall_id),
        .flush_id     (flush_id),
        .bubble_exe   (bubble_exe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_out;

    // reference model state
    logic [DEPTH-1:0] m_valid = '0;
    logic [DEPTH-1:0] m_load  = '0;
    logic [ASIZE-1:0] m_waddr [DEPTH];
    logic             m_flush = 1'b0;
    int               m_cnt   = 0;

    task automatic chk(input string tag, input logic [DSIZE-1:0] got, input logic [DSIZE-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
        end
    endtask

    // {stall, data} for one read port, searching youngest slot first
    function automatic logic [DSIZE:0] port_eval(input logic ren, input logic [ASIZE-1:0] ra,
                                                 input logic [DSIZE-1:0] rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (ren && m_valid[i] && (m_waddr[i] == ra)) begin
`ifdef HAZ_FWD_EN
                if (m_load[i] && (i < LOAD_LAT)) return {1'b1, rd};
                return {1'b0, slot_wdata[i*DSIZE +: DSIZE]};
`else
                return {1'b1, rd};
`endif
            end
        end
        return {1'b0, rd};
    endfunction

    function automatic logic [EW-1:0] model_out();
        logic [DSIZE:0] p1, p2;
        logic fl, st;
        if (!rst) return {id_rdata1, id_rdata2, 4'b0000};
        fl = exe_redirect || m_flush;
        p1 = port_eval(id_ren1, id_raddr1, id_rdata1);
        p2 = port_eval(id_ren2, id_raddr2, id_rdata2);
        st = (p1[DSIZE] || p2[DSIZE]) && !fl;
        return {p1[DSIZE-1:0], p2[DSIZE-1:0], st, st, fl, fl || st};
    endfunction

    task automatic model_step(input logic bub);
        if (!rst) begin
            m_valid = '0;
            m_load  = '0;
            m_flush = 1'b0;
            m_cnt   = 0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                m_valid[i] = m_valid[i-1];
                m_waddr[i] = m_waddr[i-1];
                m_load[i]  = m_load[i-1];
            end
            m_valid[0] = id_valid && id_wen && !bub;
            m_waddr[0] = id_waddr;
            m_load[0]  = id_is_load;
            if (exe_redirect) begin
                m_cnt   = FLUSH_N - 1;
                m_flush = (m_cnt > 0);
            end else if (m_flush) begin
                m_cnt--;
                if (m_cnt == 0) m_flush = 1'b0;
            end
        end
    endtask

    // one clock: push expectation, sample after settle, pop and compare, advance the model
    task automatic cycle();
        logic [EW-1:0] e;
        exp_q.push_back(model_out());
        #1;
        last_out = {fwd_rdata1, fwd_rdata2, stall_pc, stall_id, flush_id, bubble_exe};
        if (exp_q.size() == 0) begin
            chk("queue_empty", 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            chk("fwd_rdata1", last_out[35:20], e[35:20]);
            chk("fwd_rdata2", last_out[19:4], e[19:4]);
            chk("stall_pc", {15'd0, last_out[3]}, {15'd0, e[3]});
            chk("stall_id", {15'd0, last_out[2]}, {15'd0, e[2]});
            chk("flush_id", {15'd0, last_out[1]}, {15'd0, e[1]});
            chk("bubble_exe", {15'd0, last_out[0]}, {15'd0, e[0]});
            chk("flush_stall_excl", {15'd0, flush_id & stall_id}, 16'd0);
            @(posedge clk);
            model_step(e[0]);
        end
        @(negedge clk);
    endtask

    // driver tasks
    task automatic set_id(input logic v, input logic [3:0] w, input logic we, input logic ld,
                          input logic [3:0] r1, input logic re1, input logic [3:0] r2, input logic re2);
        id_valid   = v;
        id_waddr   = w;
        id_wen     = we;
        id_is_load = ld;
        id_raddr1  = r1;
        id_ren1    = re1;
        id_raddr2  = r2;
        id_ren2    = re2;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exe_redirect = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        @(negedge clk);
        // reset with a pending redirect: controls stay low, operands pass through
        exe_redirect = 1'b1;
        set_id(1, 1, 1, 0, 1, 1, 0, 0);
        cycle();
        chk("rst_ctrl", {12'd0, last_out[3:0]}, 16'd0);
        chk("rst_fwd1", last_out[35:20], 16'h1234);
        cycle();
        rst = 1'b1;
        idle(2);

        // ADD r1 in EXE, ID reads r1
        set_id(1, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        slot_wdata = {16'h0000, 16'h0000, 16'h0042};
        set_id(0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
`ifdef HAZ_FWD_EN
        chk("add_fwd", last_out[35:20], 16'h0042);
        chk("add_nostall", {15'd0, last_out[3]}, 16'd0);
`else
        chk("add_interlock", {15'd0, last_out[3]}, 16'd1);
`endif
        idle(4);

        // two writes to r1 in flight, read via port 2: youngest wins
        set_id(1, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        slot_wdata = {16'h0000, 16'h0022, 16'h0011};
        set_id(0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
`ifdef HAZ_FWD_EN
        chk("youngest_fwd2", last_out[19:4], 16'h0011);
`else
        chk("youngest_stall", {15'd0, last_out[3]}, 16'd1);
`endif
        idle(4);

        // load-use on r2
        set_id(1, 2, 1, 1, 0, 0, 0, 0);
        cycle();
        slot_wdata = {16'h0000, 16'hBEEF, 16'hDEAD};
        set_id(0, 0, 0, 0, 2, 1, 0, 0);
        cycle();
        chk("lu_stall", {14'd0, last_out[3], last_out[0]}, 16'd3);
        cycle();
`ifdef HAZ_FWD_EN
        chk("lu_fwd_dm", last_out[35:20], 16'hBEEF);
        chk("lu_released", {15'd0, last_out[3]}, 16'd0);
`else
        chk("lu_interlock", {15'd0, last_out[3]}, 16'd1);
`endif
        idle(4);

        // redirect in the same cycle as a load-use
        set_id(1, 2, 1, 1, 0, 0, 0, 0);
        cycle();
        set_id(0, 0, 0, 0, 2, 1, 0, 0);
        exe_redirect = 1'b1;
        cycle();
        chk("redir_flush0", {13'd0, last_out[3:1]}, 16'd1);
        exe_redirect = 1'b0;
        cycle();
        chk("redir_flush1", {13'd0, last_out[3:1]}, 16'd1);
        set_id(0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        chk("redir_done", {12'd0, last_out[3:0]}, 16'd0);
        idle(4);

        // jal writes r15, sits in DM, ID reads r15
        set_id(1, 4'hF, 1, 0, 0, 0, 0, 0);
        cycle();
        idle(1);
        slot_wdata = {16'h0000, 16'h0008, 16'h0000};
        set_id(0, 0, 0, 0, 4'hF, 1, 0, 0);
        cycle();
`ifdef HAZ_FWD_EN
        chk("jal_fwd", last_out[35:20], 16'h0008);
`else
        chk("jal_stall", {15'd0, last_out[3]}, 16'd1);
`endif
        idle(4);

        // reset while flushing drops the flush and empties the slots
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exe_redirect = 1'b1;
        cycle();
        exe_redirect = 1'b0;
        rst = 1'b0;
        cycle();
        chk("rstflush_ctrl", {12'd0, last_out[3:0]}, 16'd0);
        rst = 1'b1;
        set_id(0, 0, 0, 0, 5, 1, 0, 0);
        cycle();
        chk("rstflush_empty", {12'd0, last_out[3:0]}, 16'd0);
        chk("rstflush_fwd", last_out[35:20], 16'h1234);
        idle(4);

        // match in the WB slot
        set_id(1, 7, 1, 0, 0, 0, 0, 0);
        cycle();
        idle(2);
        slot_wdata = {16'h7777, 16'h0000, 16'h0000};
        set_id(0, 0, 0, 0, 7, 1, 0, 0);
        cycle();
`ifdef HAZ_FWD_EN
        chk("wb_fwd", last_out[35:20], 16'h7777);
`else
        chk("wb_stall", {15'd0, last_out[3]}, 16'd1);
`endif
        cycle();
        chk("wb_retired", {15'd0, last_out[3]}, 16'd0);
        idle(2);

        // random traffic on a small register range
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            set_id(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            exe_redirect = ($urandom_range(0, 7) == 0);
            slot_wdata   = {16'($urandom), 16'($urandom), 16'($urandom)};
            id_rdata1    = 16'($urandom);
            id_rdata2    = 16'($urandom);
            cycle();
        end

        chk("queue_drain", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
